// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the five-stage MIPS32 MCU core.
// Merges per-stage stall requests into the 6-bit stall vector, raises flush
// and a redirect PC on exceptions and eret, runs the debug halt/drain
// handshake, and flags bus hangs with a sticky stall watchdog.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int          DRAIN_CYCLES   = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_it,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  input  logic        halt_req,
  input  logic        timeout_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        halt_ack,
  output logic        stall_timeout
);

  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [31:0] ERET_CODE  = 32'h0000_000e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;
  logic [5:0]  req_vec;
  logic        exc;
  logic        flush_int;

  // Priority-merge the stage requests: a deeper stage freezes everything upstream.
  always_comb begin
    req_vec = 6'b000000;
    if (stallreq_mem) begin
      req_vec = 6'b011111;
    end else if (stallreq_ex) begin
      req_vec = 6'b001111;
    end else if (stallreq_it) begin
      req_vec = 6'b000111;
    end
  end

  // Exceptions are only honoured outside HALTED; reset masks everything.
  always_comb begin
    exc       = (excepttype != 32'h0000_0000);
    flush_int = !rst && exc && (state_q != HALTED);
  end

  // Output decode: zero-latency response to requests and exceptions.
  always_comb begin
    stall    = 6'b000000;
    flush    = 1'b0;
    new_pc   = 32'h0000_0000;
    halt_ack = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN, DRAIN: begin
          if (exc) begin
            flush  = 1'b1;
            new_pc = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
          end else if (state_q == DRAIN) begin
            stall = 6'b000011 | req_vec;
          end else begin
            stall = req_vec;
          end
        end
        HALTED: begin
          stall    = 6'b111111;
          halt_ack = 1'b1;
        end
        default: begin
          stall = 6'b000000;
        end
      endcase
    end
  end

  assign stall_timeout = !rst && timeout_q;

  // Next-state logic for the halt FSM and its drain counter.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      RUN: begin
        if (halt_req && !exc) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (!halt_req) begin
          state_d = RUN;
          drain_d = 4'd0;
        end else if (exc) begin
          drain_d = DRAIN_LOAD;
        end else if (req_vec == 6'b000000) begin
          if (drain_q <= 4'd1) begin
            state_d = HALTED;
            drain_d = 4'd0;
          end else begin
            drain_d = drain_q - 4'd1;
          end
        end
      end
      HALTED: begin
        if (!halt_req) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        drain_d = 4'd0;
      end
    endcase
  end

  // Watchdog: count consecutive stalled cycles, saturate, and latch a sticky flag.
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if ((req_vec == 6'b000000) || flush_int) begin
      wd_d = 16'd0;
    end else if ((state_q != HALTED) && (wd_q < TIMEOUT_CYCLES)) begin
      wd_d = wd_q + 16'd1;
    end
    if (wd_q == TIMEOUT_CYCLES) begin
      timeout_d = 1'b1;
    end else if (timeout_clr) begin
      timeout_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      drain_q   <= 4'd0;
      wd_q      <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl with
// hand-computed expectations (watchdog limit shortened to 8 cycles).
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_it;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic        halt_req;
  logic        timeout_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        halt_ack;
  logic        stall_timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_ctrl #(
    .EXC_VECTOR    (32'h0000_0020),
    .DRAIN_CYCLES  (4),
    .TIMEOUT_CYCLES(16'd8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_it  (stallreq_it),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype   (excepttype),
    .cp0_epc      (cp0_epc),
    .halt_req     (halt_req),
    .timeout_clr  (timeout_clr),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .halt_ack     (halt_ack),
    .stall_timeout(stall_timeout)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all non-reset inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic it, input logic ex, input logic mem,
                               input logic [31:0] exc, input logic [31:0] epc,
                               input logic halt, input logic clr);
    stallreq_it  = it;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excepttype   = exc;
    cp0_epc      = epc;
    halt_req     = halt;
    timeout_clr  = clr;
    #1;
  endtask

  // Compare every output against the expected values for this step.
  task automatic checkOutput(input string tag, input logic [5:0] e_stall,
                             input logic e_flush, input logic [31:0] e_pc,
                             input logic e_ack, input logic e_to);
    n_cmp++;
    assert (stall === e_stall) else begin
      n_fail++;
      $error("[TB] FAIL %s.stall observed=%b expected=%b", tag, stall, e_stall);
    end
    n_cmp++;
    assert (flush === e_flush) else begin
      n_fail++;
      $error("[TB] FAIL %s.flush observed=%b expected=%b", tag, flush, e_flush);
    end
    n_cmp++;
    assert (new_pc === e_pc) else begin
      n_fail++;
      $error("[TB] FAIL %s.new_pc observed=%h expected=%h", tag, new_pc, e_pc);
    end
    n_cmp++;
    assert (halt_ack === e_ack) else begin
      n_fail++;
      $error("[TB] FAIL %s.halt_ack observed=%b expected=%b", tag, halt_ack, e_ack);
    end
    n_cmp++;
    assert (stall_timeout === e_to) else begin
      n_fail++;
      $error("[TB] FAIL %s.stall_timeout observed=%b expected=%b", tag, stall_timeout, e_to);
    end
  endtask

  // Directed sequence: reset, stall merge, exceptions, halt/drain, watchdog.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("reset_forced_stall", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1, 32'h0, 1'b1, 1'b0);
    checkOutput("reset_forced_flush", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("after_reset", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Stall merge in RUN.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("req_ex_it", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("req_mem_ex_it", 6'b011111, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("req_it", 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("req_none", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Exceptions override stalls.
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
    checkOutput("exc_vector", 6'b000000, 1'b1, 32'h0000_0020, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_000e, 32'h0000_0100, 1'b0, 1'b0);
    checkOutput("exc_eret", 6'b000000, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0100, 1'b0, 1'b0);
    checkOutput("exc_gone", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Clean halt: rise cycle in RUN, four drain cycles, halted on the fifth.
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("halt_rise_run", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("drain_clean", 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    tick();
    checkOutput("halted", 6'b111111, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h1, 32'h0, 1'b1, 1'b0);
    checkOutput("halted_exc_ignored", 6'b111111, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("halt_drop_same_cycle", 6'b111111, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("resumed", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Halt with two ex-stall cycles in DRAIN: ack delayed by two cycles.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("halt2_rise", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("halt2_drain_c4", 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("halt2_ex_stall_a", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("halt2_ex_stall_b", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("halt2_drain_rest", 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    checkOutput("halt2_halted", 6'b111111, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("halt2_resumed", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Exception mid-DRAIN reloads the counter: four more clean cycles needed.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("halt3_drain_c4", 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("halt3_drain_c3", 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h3, 32'h0, 1'b1, 1'b0);
    checkOutput("halt3_exc", 6'b000000, 1'b1, 32'h0000_0020, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("halt3_reload_c4", 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("halt3_reload_rest", 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    tick();
    checkOutput("halt3_halted", 6'b111111, 1'b0, 32'h0, 1'b1, 1'b0);

    // Reset while HALTED: outputs drop at once, then a full drain is needed again.
    rst = 1'b1;
    #1;
    checkOutput("rst_in_halted", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_back_to_run", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rst_full_drain", 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    tick();
    checkOutput("rst_rehalted", 6'b111111, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("rst_resumed", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Watchdog: counter hits 8 after eight stalled edges, flag registers one edge later.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("wd_start", 6'b011111, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    checkOutput("wd_count7", 6'b011111, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("wd_at_limit", 6'b011111, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("wd_release", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("wd_timeout_set", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("wd_timeout_sticky", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("wd_clr_same_cycle", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("wd_cleared", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Set and clear coinciding: the set wins while the counter sits at the limit.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
    end
    checkOutput("wd2_set", 6'b011111, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("wd2_set_wins", 6'b011111, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("wd2_cleared", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage MIPS32 MCU core. It merges per-stage stall requests into the 6-bit `stall` vector consumed by every pipeline register: PC, IF/IT, IT/EX, EX/MEM, MEM/WB. It also generates the `flush` pulse and redirect `new_pc` on exceptions and `eret`, and implements a debug halt handshake that drains the pipeline before freezing it. A stall watchdog flags bus hangs.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h0000_0020: redirect address for any exception other than `eret`.
- `DRAIN_CYCLES`, 4: bubble-insertion cycles needed to empty the pipeline on halt (1..15).
- `TIMEOUT_CYCLES`, 16'd1024: consecutive stalled cycles before `stall_timeout` sets (≥1).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1).
- `stallreq_it`  in  1  decode stage requests stall (load-use hazard).
- `stallreq_ex`  in  1  execute stage requests stall (multi-cycle mul/div).
- `stallreq_mem`  in  1  memory stage requests stall (bus wait).
- `excepttype`  in  32  exception code from MEM stage; 0 = none, 32'h0000_000e = `eret`.
- `cp0_epc`  in  32  current EPC from CP0.
- `halt_req`  in  1  debug halt request, level; held until `halt_ack` then until resume.
- `timeout_clr`  in  1  clears sticky `stall_timeout`.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 IT, bit3 EX, bit4 MEM, bit5 WB; 1 = `Stop`.
- `flush`  out  1  clear all pipeline registers this cycle.
- `new_pc`  out  32  PC redirect target, valid while `flush`=1, else 0.
- `halt_ack`  out  1  pipeline empty and frozen.
- `stall_timeout`  out  1  sticky watchdog flag.

## Operation
- States: RUN, DRAIN, HALTED. Reset state RUN, drain counter 0, watchdog counter 0.
- Stall vector from requests (highest stage wins):
  - `stallreq_mem` → 6'b011111
  - else `stallreq_ex` → 6'b001111
  - else `stallreq_it` → 6'b000111
  - else 6'b000000.
- RUN:
  - If `excepttype`≠0: `flush`=1 and `stall`=0, overriding all requests. `new_pc` = `cp0_epc` if `excepttype`=32'h0000_000e, else `EXC_VECTOR`. State stays RUN.
  - Else `stall` = request vector.
  - `halt_req`=1 and no exception: next state DRAIN, counter loads `DRAIN_CYCLES`.
- DRAIN:
  - `stall` = 6'b000011 OR request vector. Fetch stops; IF/IT inserts bubbles.
  - Counter decrements only in cycles where the request vector is 0.
  - Counter reaching 0 on a decrement → HALTED.
  - Exception in DRAIN: `flush`/`new_pc` as in RUN, and counter reloads `DRAIN_CYCLES`.
  - `halt_req` dropping in DRAIN → RUN next cycle.
- HALTED:
  - `stall`=6'b111111, `halt_ack`=1, `flush`=0; `excepttype` ignored.
  - `halt_req`=0 → RUN next cycle; `halt_ack` falls with the state change.
- Watchdog:
  - Counter (16 bit) increments each cycle in RUN/DRAIN where the request vector ≠ 0.
  - Clears on any cycle with request vector 0, or with `flush`=1.
  - Saturates at `TIMEOUT_CYCLES`.
  - `stall_timeout` is registered: it sets the cycle after the counter reaches `TIMEOUT_CYCLES` and holds until `timeout_clr` or `rst`. If `timeout_clr` and set coincide, set wins.

## Timing
- `stall`, `flush`, `new_pc` are combinational from state and inputs: zero-latency, same-cycle response to requests and exceptions.
- While `rst`=1, all outputs are forced to 0 combinationally. After the reset edge:
  - `stall`=0, `flush`=0, `new_pc`=0, `halt_ack`=0, `stall_timeout`=0.
- `halt_ack` is decoded from state: it asserts the cycle after the final drain decrement. Minimum halt latency is `DRAIN_CYCLES`+1 cycles from `halt_req` rising with no stalls.
- `rst` mid-DRAIN or in HALTED: next cycle RUN with all counters 0.
- `flush` is asserted for exactly as many cycles as `excepttype`≠0; MEM/WB clearing on flush removes the source the following cycle.

## Test plan
- `stallreq_ex`=1, `stallreq_it`=1 in RUN → `stall`=6'b001111 same cycle; add `stallreq_mem`=1 → 6'b011111; release all → 6'b000000.
- `excepttype`=32'h0000_0001 with `stallreq_mem`=1 → `flush`=1, `stall`=0, `new_pc`=32'h20. Then `excepttype`=32'h0e, `cp0_epc`=32'h0000_0100 → `new_pc`=32'h100.
- `halt_req` rises, no stalls → `stall`=6'b000011 for 4 cycles; `halt_ack`=1 and `stall`=6'b111111 on cycle 5. Drop `halt_req` → next cycle `halt_ack`=0, `stall`=0.
- Halt with `stallreq_ex`=1 for 2 cycles during DRAIN → `halt_ack` delayed by 2 cycles, `stall`=6'b001111 in those cycles. Exception mid-DRAIN → counter reloads, another 4 clean cycles required.
- `TIMEOUT_CYCLES`=8, `stallreq_mem` held → `stall_timeout` rises after cycle 8 and stays set after the release. `timeout_clr`=1 → cleared next cycle.
- `rst` asserted in HALTED → all outputs 0 immediately; after release, state RUN and a fresh `halt_req` needs the full drain again.
